// File: rtl/obj_line_compositor.sv
// obj_line_compositor: scanline sprite renderer with a ping-pong line buffer.
// Define OBJ_MIRROR_EN to honour the per-object horizontal flip bit.
module obj_line_compositor #(
  parameter int NUM_OBJ   = 8,
  parameter int OBJ_SIZE  = 16,
  parameter int COLOR_W   = 3,
  parameter int TILE_ID_W = 3,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int H_ACTIVE  = 640,
  localparam int IDX_W = $clog2(NUM_OBJ),
  localparam int S_W   = $clog2(OBJ_SIZE),
  localparam int ENT_W = 2 + TILE_ID_W + X_W + Y_W,
  localparam int TA_W  = TILE_ID_W + 2 * S_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               iLine_start,
  input  logic [Y_W-1:0]     iNext_line,
  input  logic               iPix_en,
  input  logic [X_W-1:0]     iX,
  input  logic [COLOR_W-1:0] iBkg_rgb,
  output logic [COLOR_W-1:0] oRGB,
  output logic [IDX_W-1:0]   oObjRam_addr,
  input  logic [ENT_W-1:0]   iObjRam_data,
  output logic [TA_W-1:0]    oTile_addr,
  input  logic [COLOR_W-1:0] iTile_data,
  output logic               oBusy,
  output logic               oOverrun,
  output logic [IDX_W:0]     oHit_cnt
);

  localparam int AW = $clog2(H_ACTIVE);

  typedef enum logic [2:0] {
    CLR, IDLE, RD_ENT, CHK, FETCH, DRAIN
  } state_t;

  state_t state, nxt;

  logic [AW-1:0]      clrCnt;
  logic               frontB;
  logic [Y_W-1:0]     lineR;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W:0]     hitCnt;
  logic [S_W-1:0]     col;
  logic [S_W-1:0]     colEff;
  logic [TILE_ID_W-1:0] tileR;
  logic [S_W-1:0]     rowR;
  logic [X_W-1:0]     xR;
  logic               pend;
  logic [X_W:0]       pendX;

  logic [COLOR_W-1:0] bufA [H_ACTIVE];
  logic [COLOR_W-1:0] bufB [H_ACTIVE];

  logic               entEn;
  logic [TILE_ID_W-1:0] entTile;
  logic [X_W-1:0]     entX;
  logic [Y_W-1:0]     entY;
  logic [Y_W-1:0]     row;
  logic               hit;
  logic               start;

  assign entEn   = iObjRam_data[ENT_W-1];
  assign entTile = iObjRam_data[X_W+Y_W +: TILE_ID_W];
  assign entX    = iObjRam_data[Y_W +: X_W];
  assign entY    = iObjRam_data[0 +: Y_W];

  assign row   = lineR - entY;
  assign hit   = entEn && (entY <= lineR)
              && (row < Y_W'(OBJ_SIZE));
  assign start = iLine_start && (state != CLR);

  assign oBusy        = (state != IDLE);
  assign oObjRam_addr = idx;
  assign oTile_addr   = {tileR, rowR, colEff};

`ifdef OBJ_MIRROR_EN
  logic flipR;
  assign colEff = flipR ? ~col : col;
`else
  logic unusedFlip;
  assign unusedFlip = iObjRam_data[ENT_W-2];
  assign colEff     = col;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CLR;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      CLR:
        if (clrCnt == AW'(H_ACTIVE - 1))
          nxt = IDLE;
      IDLE:   nxt = IDLE;
      RD_ENT: nxt = CHK;
      CHK:
        if (hit)                  nxt = FETCH;
        else if (idx == '0)       nxt = IDLE;
        else                      nxt = RD_ENT;
      FETCH:
        if (col == '1) nxt = DRAIN;
      DRAIN:
        nxt = (idx == '0) ? IDLE : RD_ENT;
      default: nxt = CLR;
    endcase
    if (start) nxt = RD_ENT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clrCnt   <= '0;
      frontB   <= 1'b0;
      lineR    <= '0;
      idx      <= '0;
      hitCnt   <= '0;
      oHit_cnt <= '0;
      oOverrun <= 1'b0;
      col      <= '0;
      tileR    <= '0;
      rowR     <= '0;
      xR       <= '0;
      pend     <= 1'b0;
      pendX    <= '0;
`ifdef OBJ_MIRROR_EN
      flipR    <= 1'b0;
`endif
    end else begin
      oOverrun <= 1'b0;
      pend     <= 1'b0;
      if (state == CLR)
        clrCnt <= clrCnt + 1'b1;
      if (start) begin
        frontB   <= ~frontB;
        lineR    <= iNext_line;
        idx      <= IDX_W'(NUM_OBJ - 1);
        hitCnt   <= '0;
        oOverrun <= (state != IDLE);
      end else begin
        case (state)
          CHK:
            if (hit) begin
              hitCnt <= hitCnt + 1'b1;
              col    <= '0;
              tileR  <= entTile;
              rowR   <= row[S_W-1:0];
              xR     <= entX;
`ifdef OBJ_MIRROR_EN
              flipR  <= iObjRam_data[ENT_W-2];
`endif
            end else if (idx == '0) begin
              oHit_cnt <= hitCnt;
            end else begin
              idx <= idx - 1'b1;
            end
          FETCH: begin
            pend  <= 1'b1;
            pendX <= (X_W+1)'(xR) + (X_W+1)'(col);
            col   <= col + 1'b1;
          end
          DRAIN:
            if (idx == '0) oHit_cnt <= hitCnt;
            else           idx <= idx - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Front buffer: display read with clear; back buffer: render writes.
  logic               pixRd;
  logic [AW-1:0]      pixIdx;
  logic [COLOR_W-1:0] frontPix;
  logic               renWe;
  logic [AW-1:0]      renIdx;

  assign pixRd    = iPix_en && (iX < X_W'(H_ACTIVE));
  assign pixIdx   = iX[AW-1:0];
  assign frontPix = frontB ? bufB[pixIdx] : bufA[pixIdx];
  assign renWe    = pend && (iTile_data != '0)
                 && (pendX < (X_W+1)'(H_ACTIVE));
  assign renIdx   = pendX[AW-1:0];

  logic               aWe, bWe;
  logic [AW-1:0]      aIdx, bIdx;
  logic [COLOR_W-1:0] aDat, bDat;

  always_comb begin
    aWe  = 1'b0;
    aIdx = '0;
    aDat = '0;
    bWe  = 1'b0;
    bIdx = '0;
    bDat = '0;
    if (state == CLR) begin
      aWe  = 1'b1;
      aIdx = clrCnt;
      bWe  = 1'b1;
      bIdx = clrCnt;
    end else if (frontB) begin
      bWe  = pixRd;
      bIdx = pixIdx;
      aWe  = renWe;
      aIdx = renIdx;
      aDat = iTile_data;
    end else begin
      aWe  = pixRd;
      aIdx = pixIdx;
      bWe  = renWe;
      bIdx = renIdx;
      bDat = iTile_data;
    end
  end

  always_ff @(posedge clk) begin
    if (aWe) bufA[aIdx] <= aDat;
  end

  always_ff @(posedge clk) begin
    if (bWe) bufB[bIdx] <= bDat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      oRGB <= '0;
    else if (!iPix_en)
      oRGB <= '0;
    else if (pixRd)
      oRGB <= (frontPix != '0) ? frontPix : iBkg_rgb;
    else
      oRGB <= iBkg_rgb;
  end

endmodule

// File: tb/tb_obj_line_compositor.sv
// tb_obj_line_compositor: directed table-driven bench with object RAM and
// tile ROM models; expected lines are built from hand-computed spans.
module tb_obj_line_compositor;

  localparam int H = 640;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        iLine_start;
  logic [9:0]  iNext_line;
  logic        iPix_en;
  logic [9:0]  iX;
  logic [2:0]  iBkg_rgb;
  logic [2:0]  oRGB;
  logic [2:0]  oObjRam_addr;
  logic [24:0] iObjRam_data;
  logic [10:0] oTile_addr;
  logic [2:0]  iTile_data;
  logic        oBusy;
  logic        oOverrun;
  logic [3:0]  oHit_cnt;

  always #5 clk = ~clk;

  obj_line_compositor dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .iLine_start  (iLine_start),
    .iNext_line   (iNext_line),
    .iPix_en      (iPix_en),
    .iX           (iX),
    .iBkg_rgb     (iBkg_rgb),
    .oRGB         (oRGB),
    .oObjRam_addr (oObjRam_addr),
    .iObjRam_data (iObjRam_data),
    .oTile_addr   (oTile_addr),
    .iTile_data   (iTile_data),
    .oBusy        (oBusy),
    .oOverrun     (oOverrun),
    .oHit_cnt     (oHit_cnt)
  );

  logic [24:0] objRam [8];
  logic [2:0]  tileMem [2048];

  always @(posedge clk) begin
    iObjRam_data <= objRam[oObjRam_addr];
    iTile_data   <= tileMem[oTile_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [2:0] expLine [H];

  typedef struct {
    string            name;
    logic [7:0][24:0] ent;
    int line, hits, cyc, bkg;
    int lo1, hi1, c1, lo2, hi2, c2, h0, h1;
  } vec_t;

  vec_t vecs [7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [24:0] mk(input int en, input int flip,
    input int tile, input int x, input int y);
    return {1'(en), 1'(flip), 3'(tile), 10'(x), 10'(y)};
  endfunction

  function automatic vec_t nv(input string name, input int line,
    input int hits, input int cyc, input int bkg);
    vec_t v;
    v.name = name;
    v.ent  = '0;
    v.line = line;
    v.hits = hits;
    v.cyc  = cyc;
    v.bkg  = bkg;
    v.lo1  = -1; v.hi1 = -2; v.c1 = 0;
    v.lo2  = -1; v.hi2 = -2; v.c2 = 0;
    v.h0   = -1; v.h1  = -1;
    return v;
  endfunction

  task automatic fillBkg(input int bkg);
    for (int x = 0; x < H; x++) expLine[x] = 3'(bkg);
  endtask

  task automatic startLine(input int line, input int ovr,
                           input string name);
    iLine_start = 1'b1;
    iNext_line  = 10'(line);
    tick;
    iLine_start = 1'b0;
    check({name, "_ovr"}, int'(oOverrun), ovr);
    check({name, "_busy"}, int'(oBusy), 1);
  endtask

  task automatic waitIdle(input string name, input int expCyc);
    int n;
    n = 0;
    while (oBusy && n < 1000) begin
      tick;
      n++;
    end
    check({name, "_cycles"}, n, expCyc);
  endtask

  task automatic showLine(input string name, input int bkg,
                          input bit doCheck);
    int bad, fx, fg, fe, e;
    bad = 0; fx = -1; fg = 0; fe = 0;
    iPix_en  = 1'b1;
    iBkg_rgb = 3'(bkg);
    for (int x = 0; x < H + 4; x++) begin
      iX = 10'(x);
      tick;
      e = (x < H) ? int'(expLine[x]) : bkg;
      if (int'(oRGB) != e) begin
        if (bad == 0) begin
          fx = x; fg = int'(oRGB); fe = e;
        end
        bad++;
      end
    end
    iPix_en = 1'b0;
    if (doCheck) begin
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s: %0d bad pixels, x=%0d got %0d expected %0d",
                 name, bad, fx, fg, fe);
      end
    end
  endtask

  task automatic clrCycles(input string name, input bit pokeStart);
    int n;
    bit ovr;
    n = 0;
    ovr = 1'b0;
    while (oBusy && n < 2000) begin
      iLine_start = pokeStart && (n == 10);
      iNext_line  = 10'd53;
      tick;
      n++;
      if (oOverrun) ovr = 1'b1;
    end
    iLine_start = 1'b0;
    check({name, "_cycles"}, n, 640);
    check({name, "_ovr"}, int'(ovr), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    iLine_start = 1'b0;
    iNext_line  = '0;
    iPix_en     = 1'b0;
    iX          = '0;
    iBkg_rgb    = '0;
    for (int k = 0; k < 8; k++) objRam[k] = '0;
    for (int a = 0; a < 2048; a++) tileMem[a] = '0;
    for (int c = 0; c < 16; c++) begin
      tileMem[2*256 + 3*16 + c] = 3'd6;
      tileMem[1*256 + c]        = 3'd3;
      tileMem[5*256 + c]        = 3'd4;
      tileMem[3*256 + c]        = (c == 2 || c == 5) ? 3'd0 : 3'd7;
      for (int r = 0; r < 16; r++) tileMem[6*256 + r*16 + c] = 3'd2;
    end
    tileMem[4*256] = 3'd1;

    vecs[0] = nv("single", 53, 1, 33, 5);
    vecs[0].ent[0] = mk(1, 0, 2, 100, 50);
    vecs[0].lo1 = 100; vecs[0].hi1 = 115; vecs[0].c1 = 6;

    vecs[1] = nv("overlap", 10, 2, 50, 1);
    vecs[1].ent[1] = mk(1, 0, 1, 200, 10);
    vecs[1].ent[0] = mk(1, 0, 5, 200, 10);
    vecs[1].lo1 = 200; vecs[1].hi1 = 215; vecs[1].c1 = 4;

    vecs[2] = nv("edge", 300, 1, 33, 2);
    vecs[2].ent[0] = mk(1, 0, 3, 630, 300);
    vecs[2].lo1 = 630; vecs[2].hi1 = 639; vecs[2].c1 = 7;
    vecs[2].h0 = 632; vecs[2].h1 = 635;

    vecs[3] = nv("offscreen", 53, 1, 33, 3);
    vecs[3].ent[0] = mk(1, 0, 2, 1020, 50);

    vecs[4] = nv("rows", 53, 2, 50, 5);
    vecs[4].ent[0] = mk(1, 0, 2, 100, 50);
    vecs[4].ent[1] = mk(1, 0, 2, 300, 60);
    vecs[4].ent[2] = mk(0, 0, 2, 400, 50);
    vecs[4].ent[3] = mk(1, 0, 2, 500, 37);
    vecs[4].ent[5] = mk(1, 0, 6, 300, 38);
    vecs[4].lo1 = 100; vecs[4].hi1 = 115; vecs[4].c1 = 6;
    vecs[4].lo2 = 300; vecs[4].hi2 = 315; vecs[4].c2 = 2;

    vecs[5] = nv("ylow", 5, 1, 33, 4);
    vecs[5].ent[1] = mk(1, 0, 6, 20, 1020);
    vecs[5].ent[0] = mk(1, 0, 6, 40, 0);
    vecs[5].lo1 = 40; vecs[5].hi1 = 55; vecs[5].c1 = 2;

    vecs[6] = nv("mirror", 400, 1, 33, 5);
    vecs[6].ent[0] = mk(1, 1, 4, 0, 400);
`ifdef OBJ_MIRROR_EN
    vecs[6].lo1 = 15; vecs[6].hi1 = 15; vecs[6].c1 = 1;
`else
    vecs[6].lo1 = 0;  vecs[6].hi1 = 0;  vecs[6].c1 = 1;
`endif

    repeat (3) tick;
    check("rst_rgb", int'(oRGB), 0);
    check("rst_objaddr", int'(oObjRam_addr), 0);
    check("rst_tileaddr", int'(oTile_addr), 0);
    check("rst_ovr", int'(oOverrun), 0);
    check("rst_hits", int'(oHit_cnt), 0);
    check("rst_busy", int'(oBusy), 1);
    reset_n = 1'b1;
    clrCycles("clr", 1'b1);

    iPix_en = 1'b0; iX = 10'd5; iBkg_rgb = 3'd5;
    tick;
    check("pix_off", int'(oRGB), 0);
    fillBkg(5);
    showLine("bkg_only", 5, 1'b1);

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 8; k++) objRam[k] = vecs[i].ent[k];
      startLine(vecs[i].line, 0, vecs[i].name);
      waitIdle(vecs[i].name, vecs[i].cyc);
      check({vecs[i].name, "_hits"}, int'(oHit_cnt), vecs[i].hits);
      startLine(700, 0, {vecs[i].name, "_swap"});
      waitIdle({vecs[i].name, "_swap"}, 16);
      for (int x = 0; x < H; x++) begin
        expLine[x] = 3'(vecs[i].bkg);
        if (x >= vecs[i].lo1 && x <= vecs[i].hi1)
          expLine[x] = 3'(vecs[i].c1);
        if (x >= vecs[i].lo2 && x <= vecs[i].hi2)
          expLine[x] = 3'(vecs[i].c2);
        if (x == vecs[i].h0 || x == vecs[i].h1)
          expLine[x] = 3'(vecs[i].bkg);
      end
      showLine(vecs[i].name, vecs[i].bkg, 1'b1);
      fillBkg(vecs[i].bkg);
      showLine({vecs[i].name, "_reread"}, vecs[i].bkg, 1'b1);
    end

    for (int k = 0; k < 8; k++) objRam[k] = mk(1, 0, 6, 20 * k, 500);
    startLine(505, 0, "ovr1");
    repeat (99) tick;
    check("ovr1_still_busy", int'(oBusy), 1);
    startLine(505, 1, "ovr2");
    tick;
    check("ovr2_pulse_end", int'(oOverrun), 0);
    waitIdle("ovr2", 151);
    check("ovr2_hits", int'(oHit_cnt), 8);
    showLine("ovr_flush", 5, 1'b0);
    startLine(700, 0, "ovr_swap");
    waitIdle("ovr_swap", 16);
    fillBkg(5);
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 16; c++) expLine[20 * k + c] = 3'd2;
    showLine("ovr_line", 5, 1'b1);

    startLine(505, 0, "mid");
    repeat (50) tick;
    reset_n = 1'b0;
    #1;
    check("mid_busy", int'(oBusy), 1);
    check("mid_hits", int'(oHit_cnt), 0);
    check("mid_tileaddr", int'(oTile_addr), 0);
    check("mid_objaddr", int'(oObjRam_addr), 0);
    tick;
    reset_n = 1'b1;
    clrCycles("mid_clr", 1'b0);
    fillBkg(6);
    showLine("post_reset", 6, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
